// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, FSM state type and hex helper for the board UART reader
//
// Purpose : frame geometry, ASCII constants, byte-shifter state enum and a
//           nibble-to-uppercase-hex converter used by board_uart_tx.
// Ports   : none (package).
package game_pkg;

   localparam int TILE_W    = 12;
   localparam int NUM_TILES = 16;
   localparam int FRAME_LEN = 57;

   localparam logic [7:0] ASCII_B  = 8'h42;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;

   typedef enum logic [1:0] {
      BTX_IDLE  = 2'd0,
      BTX_START = 2'd1,
      BTX_DATA  = 2'd2,
      BTX_STOP  = 2'd3
   } btx_state_t;

   // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'  ('A' - 10 = 0x37)
   function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (ASCII_0 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte shifter with baud counter
//
// Purpose : sends one byte as start(0), 8 data bits LSB first, stop(1).
// Ports   : clk_i, rst_i (async, active-high)
//           load_i       - accept data_i and begin a start bit on the next cycle;
//                          may be asserted in the byte_done_o cycle for gapless chars
//           data_i[7:0]  - byte to send
//           tx_o         - registered serial line, idle high
//           byte_done_o  - high during the last cycle of the stop bit
module uart_tx_byte
   import game_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       byte_done_o
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   btx_state_t    state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          term;

   assign term        = (baud_q == CW'(CLKS_PER_BIT - 1));
   assign byte_done_o = (state_q == BTX_STOP) && term;
   assign tx_o        = tx_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= BTX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else if (load_i) begin
         state_q <= BTX_START;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= data_i;
         tx_q    <= 1'b0;
      end else if (state_q != BTX_IDLE) begin
         if (term) begin
            baud_q <= '0;
            case (state_q)
               BTX_START: begin
                  state_q <= BTX_DATA;
                  tx_q    <= shift_q[0];
               end
               BTX_DATA: begin
                  if (bit_q == 3'd7) begin
                     state_q <= BTX_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end
               default: begin
                  state_q <= BTX_IDLE;
                  tx_q    <= 1'b1;
               end
            endcase
         end else begin
            baud_q <= baud_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/board_uart_tx.sv
// rtl/board_uart_tx.sv - frame sequencer sending the board snapshot as a 57-char ASCII UART frame
//
// Purpose : snapshots MatrixCopy/score/check_over/checkWin and transmits
//           'B', 48 tile hex chars, 5 score hex chars, status char, CR, LF.
// Ports   : Clk, Reset (async, active-high)
//           MatrixCopy[191:0], score[16:0], check_over, checkWin - board inputs
//           Send  - frame request, sampled while idle
//           tx    - UART line (idle high)
//           busy  - frame in progress
//           Done  - one-cycle pulse at frame end
// Option  : BOARD_TX_AUTO_EN - also start a frame when the board differs from
//           the last transmitted one.
module board_uart_tx
   import game_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [191:0] MatrixCopy,
   input  logic [16:0]  score,
   input  logic         check_over,
   input  logic         checkWin,
   input  logic         Send,
   output logic         tx,
   output logic         busy,
   output logic         Done
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   logic         busy_q, done_q;
   logic [5:0]   char_idx_q;
   logic [191:0] mat_q;
   logic [16:0]  score_q;
   logic         over_q, win_q;

   logic         go, load, byte_done;
   logic [5:0]   next_idx;
   logic [7:0]   char_d;
   logic [19:0]  score20;
   logic [3:0]   nibs [0:52];

`ifdef BOARD_TX_AUTO_EN
   logic [210:0] last_q;
   assign go = Send || ({MatrixCopy, score, check_over, checkWin} != last_q);
`else
   assign go = Send;
`endif

   // While busy the shifter is reloaded in the final stop-bit cycle with the
   // following char, so no idle time appears between chars.
   assign load     = (!busy_q && go) ||
                     (byte_done && (char_idx_q != 6'(FRAME_LEN - 1)));
   assign next_idx = busy_q ? (char_idx_q + 6'd1) : 6'd0;
   assign score20  = {3'b000, score_q};

   // Hex nibble sequence for chars 1..53: tiles MS nibble first, then score.
   always_comb begin
      for (int t = 0; t < NUM_TILES; t++) begin
         for (int j = 0; j < 3; j++) begin
            nibs[3*t + j] = mat_q[TILE_W*t + 11 - 4*j -: 4];
         end
      end
      for (int j = 0; j < 5; j++) begin
         nibs[48 + j] = score20[19 - 4*j -: 4];
      end
   end

   // Char 0 is a constant, so it is valid before the snapshot is latched.
   always_comb begin
      char_d = ASCII_B;
      case (next_idx)
         6'd0:    char_d = ASCII_B;
         6'd54:   char_d = ASCII_0 + {6'b0, win_q, over_q};
         6'd55:   char_d = ASCII_CR;
         6'd56:   char_d = ASCII_LF;
         default: if (next_idx <= 6'd53) char_d = hex2ascii(nibs[next_idx - 6'd1]);
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         char_idx_q <= '0;
         mat_q      <= '0;
         score_q    <= '0;
         over_q     <= 1'b0;
         win_q      <= 1'b0;
`ifdef BOARD_TX_AUTO_EN
         last_q     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (!busy_q) begin
            if (go) begin
               busy_q     <= 1'b1;
               char_idx_q <= '0;
               mat_q      <= MatrixCopy;
               score_q    <= score;
               over_q     <= check_over;
               win_q      <= checkWin;
`ifdef BOARD_TX_AUTO_EN
               last_q     <= {MatrixCopy, score, check_over, checkWin};
`endif
            end
         end else if (byte_done) begin
            if (char_idx_q == 6'(FRAME_LEN - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               char_idx_q <= char_idx_q + 6'd1;
            end
         end
      end
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .clk_i       (Clk),
      .rst_i       (Reset),
      .load_i      (load),
      .data_i      (char_d),
      .tx_o        (tx),
      .byte_done_o (byte_done)
   );

   assign busy = busy_q;
   assign Done = done_q;

endmodule
